// File: rtl/if_fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int PC_BUS   = 32;
  localparam int DATA_BUS = 32;

  localparam logic [DATA_BUS-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  function automatic logic [PC_BUS-1:0] word_align(input logic [PC_BUS-1:0] addr);
    return addr & ~PC_BUS'(3);
  endfunction

  // Wraps modulo 2^32 by construction of the fixed-width add.
  function automatic logic [PC_BUS-1:0] next_pc(input logic [PC_BUS-1:0] addr);
    return addr + PC_BUS'(4);
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// One-entry {pc,instr} holding register used while decode is stalled.
module fetch_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                clear,
  input  logic [PC_BUS-1:0]   load_pc,
  input  logic [DATA_BUS-1:0] load_instr,
  output logic                valid,
  output logic [PC_BUS-1:0]   pc,
  output logic [DATA_BUS-1:0] instr
);

  // A load in the same cycle as a clear keeps the new entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a one-outstanding imem
// handshake, and presents pc/instr/if_valid to the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PC_BUS-1:0]   RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_BUS-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cu_stall,
  input  logic                cu_redirect,
  input  logic [PC_BUS-1:0]   redirect_pc,
  output logic                imem_req,
  output logic [PC_BUS-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [DATA_BUS-1:0] imem_rdata,
  output logic [PC_BUS-1:0]   pc,
  output logic [DATA_BUS-1:0] instr,
  output logic                if_valid
);

  fetch_state_t        state;
  logic [PC_BUS-1:0]   fetch_pc;
  logic                skid_valid;
  logic [PC_BUS-1:0]   skid_pc;
  logic [DATA_BUS-1:0] skid_instr;

  logic accept;
  logic resp;
  logic out_free;
  logic resp_to_out;
  logic skid_load;
  logic skid_clear;

  // A full skid buffer throttles new requests so at most two words are ever held.
  assign imem_req    = reset_n & (state == ST_REQ) & ~skid_valid;
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req & imem_ready;
  assign resp        = (state == ST_WAIT) & imem_rvalid & ~cu_redirect;
  assign out_free    = ~if_valid | ~cu_stall;
  assign resp_to_out = resp & out_free & ~skid_valid;
  assign skid_load   = resp & ~resp_to_out;
  assign skid_clear  = cu_redirect | (out_free & skid_valid);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (fetch_pc),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
    end else if (cu_redirect) begin
      fetch_pc <= word_align(redirect_pc);
      // A response still owed by memory must be swallowed in DROP.
      case (state)
        ST_REQ:  state <= accept ? ST_DROP : ST_REQ;
        ST_WAIT: state <= imem_rvalid ? ST_REQ : ST_DROP;
        ST_DROP: state <= imem_rvalid ? ST_REQ : ST_DROP;
        default: state <= ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (accept) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            fetch_pc <= next_pc(fetch_pc);
            state    <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) state <= ST_REQ;
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  // Output register: skid contents are older than a fresh response, so they go first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_valid <= 1'b0;
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
    end else if (cu_redirect) begin
      if_valid <= 1'b0;
      instr    <= NOP_INSTR;
    end else if (out_free) begin
      if (skid_valid) begin
        if_valid <= 1'b1;
        pc       <= skid_pc;
        instr    <= skid_instr;
      end else if (resp_to_out) begin
        if_valid <= 1'b1;
        pc       <= fetch_pc;
        instr    <= imem_rdata;
      end else begin
        if_valid <= 1'b0;
        instr    <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch, stall/skid, redirect, wrap, reset.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        cu_stall;
  logic        cu_redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        if_valid;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cu_stall    (cu_stall),
    .cu_redirect (cu_redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .if_valid    (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    cu_stall    = 1'b0;
    cu_redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    step();
    step();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOP);

    // Reset release, zero-wait memory
    reset_n    = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk("t1_req0", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 32'h0);
    step();                                   // accept addr 0
    chk("t1_wait_req", imem_req, 1'b0);
    chk("t1_valid_c0", if_valid, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_FFFF;
    step();                                   // first word lands
    imem_rvalid = 1'b0;
    chk("t1_valid_c1", if_valid, 1'b1);
    chk("t1_pc0", pc, 32'h0);
    chk("t1_instr0", instr, 32'h0000_FFFF);
    chk("t1_addr4", imem_addr, 32'h4);
    step();                                   // accept addr 4, word 0 consumed
    chk("t1_bubble", if_valid, 1'b0);
    chk("t1_bubble_instr", instr, NOP);
    imem_rvalid = 1'b1; imem_rdata = 32'h0004_FFFB;
    step();
    imem_rvalid = 1'b0;
    chk("t1_pc4", pc, 32'h4);
    chk("t1_instr4", instr, 32'h0004_FFFB);

    // Stall for five cycles while the next word arrives
    cu_stall = 1'b1;
    step();                                   // accept addr 8, output held
    chk("t2_hold_pc", pc, 32'h4);
    imem_rvalid = 1'b1; imem_rdata = 32'h0008_FFF7;
    step();                                   // word 8 goes to skid
    imem_rvalid = 1'b0;
    chk("t2_skid_noreq", imem_req, 1'b0);
    chk("t2_hold_instr", instr, 32'h0004_FFFB);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall_noreq", imem_req, 1'b0);
      chk("t2_stall_valid", if_valid, 1'b1);
      chk("t2_stall_pc", pc, 32'h4);
    end
    cu_stall = 1'b0;
    step();                                   // skid word moves to output
    chk("t2_skid_pc", pc, 32'h8);
    chk("t2_skid_instr", instr, 32'h0008_FFF7);
    chk("t2_resume_req", imem_req, 1'b1);
    chk("t2_resume_addr", imem_addr, 32'hC);
    step();                                   // accept addr C, now WAIT
    chk("t2_after_valid", if_valid, 1'b0);

    // Redirect while waiting
    cu_redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    cu_redirect = 1'b0;
    chk("t3_drop_noreq", imem_req, 1'b0);
    chk("t3_valid_low", if_valid, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'h000C_FFF3;
    step();                                   // stale word swallowed
    imem_rvalid = 1'b0;
    chk("t3_discard_valid", if_valid, 1'b0);
    chk("t3_discard_instr", instr, NOP);
    chk("t3_req", imem_req, 1'b1);
    chk("t3_addr", imem_addr, 32'h0000_0100);

    // Memory not ready, redirect on the third cycle
    imem_ready = 1'b0;
    step();
    chk("t4_req_held", imem_req, 1'b1);
    step();
    chk("t4_addr_held", imem_addr, 32'h0000_0100);
    cu_redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    cu_redirect = 1'b0;
    chk("t4_req_new", imem_req, 1'b1);
    chk("t4_addr_new", imem_addr, 32'h0000_0040);
    imem_ready = 1'b1;
    step();                                   // accept 0x40
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_FFBF;
    step();
    imem_rvalid = 1'b0;
    chk("t4_pc", pc, 32'h0000_0040);
    chk("t4_instr", instr, 32'h0000_FFBF);
    chk("t4_next_addr", imem_addr, 32'h0000_0044);

    // PC wrap at the top of the address space
    imem_ready = 1'b0;
    cu_redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    cu_redirect = 1'b0;
    chk("t5_align", imem_addr, 32'hFFFF_FFFC);
    chk("t5_redir_valid", if_valid, 1'b0);
    imem_ready = 1'b1;
    step();                                   // accept FFFF_FFFC
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_0003;
    step();
    imem_rvalid = 1'b0;
    chk("t5_pc", pc, 32'hFFFF_FFFC);
    chk("t5_instr", instr, 32'hFFFF_0003);
    chk("t5_wrap_addr", imem_addr, 32'h0000_0000);

    // Redirect in the same cycle as the response
    step();                                   // accept addr 0
    cu_redirect = 1'b1; redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    step();
    cu_redirect = 1'b0; imem_rvalid = 1'b0;
    chk("t5b_valid", if_valid, 1'b0);
    chk("t5b_instr", instr, NOP);
    chk("t5b_req", imem_req, 1'b1);
    chk("t5b_addr", imem_addr, 32'h0000_0200);

    // Asynchronous reset while waiting, then a stray response
    step();                                   // accept 0x200
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req", imem_req, 1'b0);
    chk("t6_rst_valid", if_valid, 1'b0);
    chk("t6_rst_pc", pc, 32'h0);
    step();
    reset_n = 1'b1;
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    step();                                   // stray data in REQ
    imem_rvalid = 1'b0;
    chk("t6_stray_valid", if_valid, 1'b0);
    chk("t6_stray_instr", instr, NOP);
    chk("t6_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    step();                                   // accept addr 0
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_FFFF;
    step();
    imem_rvalid = 1'b0;
    chk("t6_first_valid", if_valid, 1'b1);
    chk("t6_first_pc", pc, 32'h0);
    chk("t6_first_instr", instr, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
